// File: rtl/game_pkg.sv
// Shared types and helpers for the lane-runner game-flow controller.
package game_pkg;

  // Top-level game flow states, in the order the game walks through them.
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    COUNTDOWN = 3'd1,
    LOGO_OUT  = 3'd2,
    PLAYER_IN = 3'd3,
    PLAY      = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  // Default two's-complement width of all layer offsets.
  localparam int DEFAULT_OFS_W = 12;

  // Horizontal offset of a lane centre relative to the middle lane. The
  // middle lane index uses integer division, so an even lane count leans
  // left. The caller truncates the result to its offset width.
  function automatic int lane_offset(input int lane, input int num_lanes, input int pitch);
    return (lane - (num_lanes - 1) / 2) * pitch;
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for a synchronised button level. The previous level
// is only refreshed on frame ticks, so a press held across several ticks
// produces a single rise pulse, and that pulse is only valid in a tick cycle.
module tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember the button level seen at the most recent frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (tick) begin
      prev <= level;
    end
  end

  assign rise = tick & level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller for the lane-runner display pipeline: intro
// countdown, logo slide-out, player slide-in, then lane play with coin
// scoring and obstacle spawning. Everything advances on frame_tick only.
//
// Build option GAME_SEQ_GAMEOVER_EN: when defined, obstacle collisions cost
// lives (with a post-hit immunity window) and running out ends the game in
// GAME_OVER. When undefined the game is a demo: collisions are ignored,
// lives is fixed and GAME_OVER cannot be reached.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LANES     = 3,
  parameter int OFS_W         = DEFAULT_OFS_W,
  parameter int LANE_PITCH    = 100,
  parameter int COUNT_FRAMES  = 5,
  parameter int LOGO_STEP     = 30,
  parameter int LOGO_END      = 640,
  parameter int PLAYER_START  = 180,
  parameter int PLAYER_STEP   = 20,
  parameter int PLAYER_END    = 50,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 30,
  parameter int SCORE_W       = 16,
  parameter int OBS_THRESH    = 26
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  input  logic                         frame_tick,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic [19:0]                  random,
  input  logic                         obs_active,
  input  logic [NUM_LANES-1:0]         obs_arrive,
  input  logic [NUM_LANES-1:0]         coin_arrive,
  output state_t                       state,
  output logic signed [OFS_W-1:0]      logo_voffset,
  output logic signed [OFS_W-1:0]      player_voffset,
  output logic signed [OFS_W-1:0]      player_hoffset,
  output logic [$clog2(NUM_LANES)-1:0] player_lane,
  output logic [NUM_LANES-1:0]         coin_spawn,
  output logic [NUM_LANES-1:0]         obs_spawn,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives
);

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = (COUNT_FRAMES > 0) ? $clog2(COUNT_FRAMES + 1) : 1;

  localparam logic [LANE_W-1:0]       CENTER_LANE    = LANE_W'((NUM_LANES - 1) / 2);
  localparam logic [LANE_W-1:0]       LAST_LANE      = LANE_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]        COUNT_INIT     = CNT_W'(COUNT_FRAMES);
  localparam logic signed [OFS_W-1:0] LOGO_STEP_S    = OFS_W'(LOGO_STEP);
  localparam logic signed [OFS_W-1:0] LOGO_END_S     = OFS_W'(LOGO_END);
  localparam logic signed [OFS_W-1:0] PLAYER_START_S = OFS_W'(PLAYER_START);
  localparam logic signed [OFS_W-1:0] PLAYER_STEP_S  = OFS_W'(PLAYER_STEP);
  localparam logic signed [OFS_W-1:0] PLAYER_END_S   = OFS_W'(PLAYER_END);
  localparam logic signed [OFS_W-1:0] CENTER_HOFS    =
    OFS_W'(lane_offset(int'(CENTER_LANE), NUM_LANES, LANE_PITCH));

  // Score increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  state_next;
  logic [CNT_W-1:0]        countdown;
  logic [LANE_W-1:0]       lane_next;
  logic [NUM_LANES-1:0]    coin_sticky;
  logic [NUM_LANES-1:0]    coin_eff;
  logic [NUM_LANES-1:0]    spawn_onehot;
  logic                    coin_hit;
  logic                    press_left;
  logic                    press_right;
  logic                    load_init;
  logic                    last_life;

  // Button edge detectors, refreshed on frame ticks only.
  tick_edge u_edge_left (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .tick  (frame_tick),
    .level (btn_left),
    .rise  (press_left)
  );

  tick_edge u_edge_right (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .tick  (frame_tick),
    .level (btn_right),
    .rise  (press_right)
  );

  // Entering RESET (or sitting in it) reloads every counter on the tick.
  assign load_init = (state == RESET) || (state_next == RESET);

  // Arrivals only count while playing: pending sticky bits plus any pulse
  // that lands exactly in the tick cycle.
  assign coin_eff = (state == PLAY) ? (coin_sticky | coin_arrive) : '0;
  assign coin_hit = coin_eff[player_lane];

  // Catch coin arrivals between ticks; the next tick consumes them.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      coin_sticky <= '0;
    end else if (frame_tick) begin
      coin_sticky <= '0;
    end else if (state == PLAY) begin
      coin_sticky <= coin_sticky | coin_arrive;
    end
  end

`ifdef GAME_SEQ_GAMEOVER_EN
  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  logic [NUM_LANES-1:0] obs_sticky;
  logic [NUM_LANES-1:0] obs_eff;
  logic [INV_W-1:0]     invuln;
  logic                 hit;
  logic                 unused_sink;

  assign obs_eff   = (state == PLAY) ? (obs_sticky | obs_arrive) : '0;
  assign hit       = obs_eff[player_lane] && (invuln == '0);
  assign last_life = hit && (lives == LIVES_W'(1));
  assign unused_sink = ^random[19:16];

  // Catch obstacle arrivals between ticks; the next tick consumes them.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      obs_sticky <= '0;
    end else if (frame_tick) begin
      obs_sticky <= '0;
    end else if (state == PLAY) begin
      obs_sticky <= obs_sticky | obs_arrive;
    end
  end

  // Lives and the post-hit immunity window.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      lives  <= LIVES_W'(LIVES);
      invuln <= '0;
    end else if (frame_tick) begin
      if (load_init) begin
        lives  <= LIVES_W'(LIVES);
        invuln <= '0;
      end else if (hit) begin
        lives  <= lives - 1'b1;
        invuln <= INV_W'(INVULN_FRAMES);
      end else if (invuln != '0) begin
        invuln <= invuln - 1'b1;
      end
    end
  end
`else
  logic unused_sink;

  assign last_life   = 1'b0;
  assign lives       = LIVES_W'(LIVES);
  assign unused_sink = ^{random[19:16], obs_arrive};
`endif

  // State register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision, evaluated only in tick cycles.
  always_comb begin
    state_next = state;
    if (frame_tick) begin
      case (state)
        RESET:     state_next = COUNTDOWN;
        COUNTDOWN: if (countdown == '0) state_next = LOGO_OUT;
        LOGO_OUT:  if (!(logo_voffset < LOGO_END_S)) state_next = PLAYER_IN;
        PLAYER_IN: if (!(player_voffset > PLAYER_END_S)) state_next = PLAY;
        PLAY:      if (last_life) state_next = GAME_OVER;
        GAME_OVER: if (btn_left && btn_right) state_next = RESET;
        default:   state_next = RESET;
      endcase
    end
  end

  // Combinational outputs: coin enables and the obstacle spawn request.
  always_comb begin
    coin_spawn   = '0;
    spawn_onehot = '0;
    if (state == PLAY) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        coin_spawn[i] = &random[3*i +: 3];
      end
      if (!obs_active && (int'(random[7:0]) < OBS_THRESH)) begin
        spawn_onehot = NUM_LANES'(1) << (int'(random[15:8]) % NUM_LANES);
      end
    end
  end

  // Lane step from button presses; simultaneous presses cancel.
  always_comb begin
    lane_next = player_lane;
    if (press_left && !press_right && (player_lane != '0)) begin
      lane_next = player_lane - 1'b1;
    end else if (press_right && !press_left && (player_lane != LAST_LANE)) begin
      lane_next = player_lane + 1'b1;
    end
  end

  // Intro counters, player position and score, all advanced per tick.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      countdown      <= COUNT_INIT;
      logo_voffset   <= '0;
      player_voffset <= PLAYER_START_S;
      player_lane    <= CENTER_LANE;
      player_hoffset <= CENTER_HOFS;
      score          <= '0;
    end else if (frame_tick) begin
      if (load_init) begin
        countdown      <= COUNT_INIT;
        logo_voffset   <= '0;
        player_voffset <= PLAYER_START_S;
        player_lane    <= CENTER_LANE;
        player_hoffset <= CENTER_HOFS;
        score          <= '0;
      end else begin
        case (state)
          COUNTDOWN: begin
            if (countdown != '0) countdown <= countdown - 1'b1;
          end
          LOGO_OUT: begin
            if (logo_voffset < LOGO_END_S) logo_voffset <= logo_voffset + LOGO_STEP_S;
          end
          PLAYER_IN: begin
            if (player_voffset > PLAYER_END_S) player_voffset <= player_voffset - PLAYER_STEP_S;
          end
          PLAY: begin
            player_lane    <= lane_next;
            player_hoffset <= OFS_W'(lane_offset(int'(lane_next), NUM_LANES, LANE_PITCH));
            if (coin_hit) score <= sat_inc(score);
          end
          default: ;
        endcase
      end
    end
  end

  // Obstacle spawn pulse: high for the single cycle after its tick.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      obs_spawn <= '0;
    end else if (frame_tick) begin
      obs_spawn <= spawn_onehot;
    end else begin
      obs_spawn <= '0;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a queue of expected values that is
// filled as stimulus is applied and drained once outputs have settled.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int NL = 3;

  localparam int SEL_STATE  = 0;
  localparam int SEL_LOGO   = 1;
  localparam int SEL_PV     = 2;
  localparam int SEL_HOFS   = 3;
  localparam int SEL_LANE   = 4;
  localparam int SEL_SCORE  = 5;
  localparam int SEL_LIVES  = 6;
  localparam int SEL_OBS    = 7;
  localparam int SEL_COIN   = 8;
  localparam int SEL_SCORE4 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          frame_tick;
  logic          btn_left;
  logic          btn_right;
  logic [19:0]   random;
  logic          obs_active;
  logic [NL-1:0] obs_arrive;
  logic [NL-1:0] coin_arrive;

  state_t             state;
  logic signed [11:0] logo_voffset, player_voffset, player_hoffset;
  logic [1:0]         player_lane;
  logic [NL-1:0]      coin_spawn, obs_spawn;
  logic [15:0]        score;
  logic [1:0]         lives;

  state_t             state4;
  logic signed [11:0] logo4, pv4, hofs4;
  logic [1:0]         lane4;
  logic [NL-1:0]      coin4, obs4;
  logic [3:0]         score4;
  logic [1:0]         lives4;

  game_sequencer #(.NUM_LANES(NL)) u_dut (
    .CLK100MHZ      (clk),
    .CPU_RESETN     (rst_n),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .random         (random),
    .obs_active     (obs_active),
    .obs_arrive     (obs_arrive),
    .coin_arrive    (coin_arrive),
    .state          (state),
    .logo_voffset   (logo_voffset),
    .player_voffset (player_voffset),
    .player_hoffset (player_hoffset),
    .player_lane    (player_lane),
    .coin_spawn     (coin_spawn),
    .obs_spawn      (obs_spawn),
    .score          (score),
    .lives          (lives)
  );

  // Narrow-score copy used for the saturation check.
  game_sequencer #(.NUM_LANES(NL), .SCORE_W(4)) u_dut4 (
    .CLK100MHZ      (clk),
    .CPU_RESETN     (rst_n),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .random         (random),
    .obs_active     (obs_active),
    .obs_arrive     (obs_arrive),
    .coin_arrive    (coin_arrive),
    .state          (state4),
    .logo_voffset   (logo4),
    .player_voffset (pv4),
    .player_hoffset (hofs4),
    .player_lane    (lane4),
    .coin_spawn     (coin4),
    .obs_spawn      (obs4),
    .score          (score4),
    .lives          (lives4)
  );

  typedef struct {
    int                 sel;
    logic signed [31:0] exp;
    string              tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic signed [31:0] observe(input int sel);
    logic signed [31:0] v;
    case (sel)
      SEL_STATE:  v = 32'(state);
      SEL_LOGO:   v = 32'(logo_voffset);
      SEL_PV:     v = 32'(player_voffset);
      SEL_HOFS:   v = 32'(player_hoffset);
      SEL_LANE:   v = 32'(player_lane);
      SEL_SCORE:  v = 32'(score);
      SEL_LIVES:  v = 32'(lives);
      SEL_OBS:    v = 32'(obs_spawn);
      SEL_COIN:   v = 32'(coin_spawn);
      SEL_SCORE4: v = 32'(score4);
      default:    v = 'x;
    endcase
    return v;
  endfunction

  task automatic expect_val(input int sel, input int exp, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic signed [31:0] o;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      total++;
      assert (o === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit left, input bit right);
    btn_left  = left;
    btn_right = right;
    tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    tick();
  endtask

  task automatic hit_tick();
    obs_arrive = 3'b010;
    tick();
    obs_arrive = '0;
  endtask

  task automatic expect_reset_values(input string tag);
    expect_val(SEL_STATE,  int'(RESET), {tag, "_state"});
    expect_val(SEL_LOGO,   0,           {tag, "_logo"});
    expect_val(SEL_PV,     180,         {tag, "_pv"});
    expect_val(SEL_LANE,   1,           {tag, "_lane"});
    expect_val(SEL_HOFS,   0,           {tag, "_hofs"});
    expect_val(SEL_SCORE,  0,           {tag, "_score"});
    expect_val(SEL_SCORE4, 0,           {tag, "_score4"});
    expect_val(SEL_LIVES,  3,           {tag, "_lives"});
    expect_val(SEL_OBS,    0,           {tag, "_obs"});
    expect_val(SEL_COIN,   0,           {tag, "_coin"});
  endtask

  // Intro from RESET to PLAY: 6 countdown ticks, logo to 660, player to 40.
  task automatic run_intro(input bit detail);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (detail) expect_val(SEL_STATE, int'(COUNTDOWN), "countdown");
    end
    if (detail) expect_val(SEL_COIN, 0, "coin_outside_play");
    check_sb();
    tick();
    expect_val(SEL_STATE, int'(LOGO_OUT), "enter_logo");
    expect_val(SEL_LOGO, 0, "logo_start");
    check_sb();
    ticks(22);
    expect_val(SEL_LOGO, 660, "logo_final");
    expect_val(SEL_STATE, int'(LOGO_OUT), "logo_still");
    check_sb();
    tick();
    expect_val(SEL_STATE, int'(PLAYER_IN), "enter_player_in");
    expect_val(SEL_PV, 180, "pv_start");
    check_sb();
    ticks(7);
    expect_val(SEL_PV, 40, "pv_final");
    expect_val(SEL_STATE, int'(PLAYER_IN), "player_in_still");
    check_sb();
    tick();
    expect_val(SEL_STATE, int'(PLAY), "enter_play");
    check_sb();
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_tick  = 1'b0;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    random      = 20'hFFFFF;
    obs_active  = 1'b0;
    obs_arrive  = '0;
    coin_arrive = '0;

    repeat (3) @(negedge clk);
    expect_reset_values("reset");
    check_sb();
    rst_n = 1'b1;

    // No tick, no progress.
    repeat (4) @(negedge clk);
    expect_val(SEL_STATE, int'(RESET), "no_tick_hold");
    check_sb();

    run_intro(1'b1);
    expect_val(SEL_COIN, 7, "coin_spawn_play");
    expect_val(SEL_LANE, 1, "lane_center");
    expect_val(SEL_HOFS, 0, "hofs_center");
    check_sb();

    // Lane movement and clamping.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    expect_val(SEL_LANE, 0, "lane_left_clamp");
    expect_val(SEL_HOFS, -100, "hofs_left");
    check_sb();
    btn_right = 1'b1;
    ticks(3);
    btn_right = 1'b0;
    tick();
    expect_val(SEL_LANE, 1, "lane_held_once");
    check_sb();
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
    expect_val(SEL_LANE, 2, "lane_right_clamp");
    expect_val(SEL_HOFS, 100, "hofs_right");
    check_sb();
    press(1'b1, 1'b1);
    expect_val(SEL_LANE, 2, "lane_both");
    expect_val(SEL_HOFS, 100, "hofs_both");
    check_sb();

    // Scoring on the player lane (lane 2).
    coin_arrive = 3'b100;
    ticks(5);
    coin_arrive = '0;
    expect_val(SEL_SCORE, 5, "score_5");
    expect_val(SEL_SCORE4, 5, "score4_5");
    check_sb();
    coin_arrive = 3'b011;
    ticks(2);
    coin_arrive = '0;
    expect_val(SEL_SCORE, 5, "score_other_lanes");
    check_sb();
    coin_arrive = 3'b100;
    ticks(20);
    coin_arrive = '0;
    expect_val(SEL_SCORE, 25, "score_25");
    expect_val(SEL_SCORE4, 15, "score4_saturate");
    check_sb();

    // Arrival between ticks is held until the next tick.
    @(negedge clk);
    coin_arrive = 3'b100;
    @(negedge clk);
    coin_arrive = '0;
    repeat (2) @(negedge clk);
    expect_val(SEL_SCORE, 25, "sticky_wait");
    check_sb();
    tick();
    expect_val(SEL_SCORE, 26, "sticky_consumed");
    expect_val(SEL_SCORE4, 15, "score4_hold");
    check_sb();

    // Obstacle spawn.
    random = 20'h00105;
    obs_active = 1'b0;
    tick();
    expect_val(SEL_OBS, 2, "obs_spawn_pulse");
    expect_val(SEL_COIN, 0, "coin_for_00105");
    check_sb();
    @(negedge clk);
    expect_val(SEL_OBS, 0, "obs_spawn_one_cycle");
    check_sb();
    obs_active = 1'b1;
    tick();
    expect_val(SEL_OBS, 0, "obs_spawn_blocked");
    check_sb();
    random = 20'hFFFFF;

    // Asynchronous reset mid-play, between ticks.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset_values("async");
    check_sb();
    @(negedge clk);
    rst_n = 1'b1;

    run_intro(1'b0);
    coin_arrive = 3'b010;
    ticks(3);
    coin_arrive = '0;
    expect_val(SEL_SCORE, 3, "score_after_restart");
    check_sb();

`ifdef GAME_SEQ_GAMEOVER_EN
    hit_tick();
    expect_val(SEL_LIVES, 2, "hit_first");
    check_sb();
    hit_tick();
    expect_val(SEL_LIVES, 2, "hit_immune_next");
    check_sb();
    ticks(28);
    hit_tick();
    expect_val(SEL_LIVES, 2, "hit_immune_last");
    check_sb();
    hit_tick();
    expect_val(SEL_LIVES, 1, "hit_tick31");
    expect_val(SEL_STATE, int'(PLAY), "still_play");
    check_sb();
    ticks(30);
    hit_tick();
    expect_val(SEL_LIVES, 0, "hit_tick62");
    expect_val(SEL_STATE, int'(GAME_OVER), "game_over");
    expect_val(SEL_COIN, 0, "game_over_coin");
    expect_val(SEL_OBS, 0, "game_over_obs");
    expect_val(SEL_SCORE, 3, "game_over_score");
    check_sb();
    random = 20'h00105;
    obs_active = 1'b0;
    coin_arrive = 3'b010;
    tick();
    coin_arrive = '0;
    expect_val(SEL_OBS, 0, "game_over_no_spawn");
    expect_val(SEL_SCORE, 3, "game_over_score_hold");
    expect_val(SEL_STATE, int'(GAME_OVER), "game_over_hold");
    check_sb();
    random = 20'hFFFFF;
    obs_active = 1'b1;
    btn_left  = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    expect_val(SEL_STATE, int'(RESET), "restart");
    expect_val(SEL_SCORE, 0, "restart_score");
    expect_val(SEL_LIVES, 3, "restart_lives");
    check_sb();
    tick();
    expect_val(SEL_STATE, int'(COUNTDOWN), "restart_countdown");
    check_sb();
`else
    hit_tick();
    hit_tick();
    expect_val(SEL_LIVES, 3, "demo_lives");
    expect_val(SEL_STATE, int'(PLAY), "demo_play");
    check_sb();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
